// File: rtl/dicerace_disp_pkg.sv
// Shared types and helpers for the display compositor: window layout record,
// source ids, the per-pixel sideband bundle and the RGB565 -> RGB444 conversion.
package dicerace_disp_pkg;

  typedef struct packed {
    logic       en;
    logic [9:0] x0;
    logic [9:0] y0;
  } win_cfg_t;

  typedef logic [11:0] rgb444_t;

  // Everything that travels alongside a pixel but does not come from the frame buffer.
  typedef struct packed {
    logic    de;
    logic    h_sync;
    logic    v_sync;
    logic    ui_en;
    rgb444_t ui_rgb;
  } side_t;

  localparam logic [2:0] CH_UI = 3'd6;
  localparam logic [2:0] CH_BG = 3'd7;

  function automatic rgb444_t rgb565_to_444(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

endpackage

// File: rtl/cam_window_addr_gen.sv
// Window hit test and frame-buffer read address for one camera channel.
// Both outputs are registered; this register is stage 0 of the compositor pipeline.
module cam_window_addr_gen #(
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120,
  parameter int SCALE_SHIFT = 1,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic [9:0]        i_x0,
  input  logic [9:0]        i_y0,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [10:0]       WIN_W     = 11'(IMG_WIDTH << SCALE_SHIFT);
  localparam logic [10:0]       WIN_H     = 11'(IMG_HEIGHT << SCALE_SHIFT);
  localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
  localparam logic [10:0]       V_LIM     = 11'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_WIDTH);

  logic [10:0]       w_x, w_y, w_x0, w_y0, w_dx, w_dy;
  logic              w_in_x, w_in_y, w_hit;
  logic [ADDR_W-1:0] w_addr;

  // 11-bit compare so a window reaching past the visible area clips instead of wrapping.
  assign w_x    = {1'b0, i_x};
  assign w_y    = {1'b0, i_y};
  assign w_x0   = {1'b0, i_x0};
  assign w_y0   = {1'b0, i_y0};
  assign w_in_x = (w_x >= w_x0) && (w_x < w_x0 + WIN_W) && (w_x < H_LIM);
  assign w_in_y = (w_y >= w_y0) && (w_y < w_y0 + WIN_H) && (w_y < V_LIM);
  assign w_hit  = i_en && w_in_x && w_in_y;
  assign w_dx   = w_x - w_x0;
  assign w_dy   = w_y - w_y0;
  assign w_addr = ADDR_W'(w_dy >> SCALE_SHIFT) * ROW_PITCH + ADDR_W'(w_dx >> SCALE_SHIFT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hit  <= 1'b0;
      o_addr <= '0;
    end else begin
      o_hit  <= w_hit;
      o_addr <= w_hit ? w_addr : '0;
    end
  end

endmodule

// File: rtl/multi_cam_compositor.sv
// N-channel camera window compositor: double-buffered layout, per-channel address
// generation, latency-aligned sideband pipeline and UI/channel/background priority mux.
module multi_cam_compositor
  import dicerace_disp_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          IMG_WIDTH   = 160,
  parameter int          IMG_HEIGHT  = 120,
  parameter int          SCALE_SHIFT = 1,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          RD_LATENCY  = 1,
  parameter logic [11:0] BG_RGB      = 12'h000,
  localparam int         ADDR_W      = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_de,
  input  logic                     i_h_sync,
  input  logic                     i_v_sync,
  input  logic [9:0]               i_x_pixel,
  input  logic [9:0]               i_y_pixel,
  output logic [NUM_CH*ADDR_W-1:0] o_rd_addr,
  input  logic [NUM_CH*16-1:0]     i_rd_data,
  input  logic                     i_ui_en,
  input  logic [11:0]              i_ui_rgb,
  input  logic                     i_cfg_valid,
  input  logic [1:0]               i_cfg_ch,
  input  logic                     i_cfg_en,
  input  logic [9:0]               i_cfg_x0,
  input  logic [9:0]               i_cfg_y0,
  output logic                     o_cfg_applied,
  output logic [11:0]              o_rgb_out,
  output logic                     o_de_out,
  output logic                     o_h_sync_out,
  output logic                     o_v_sync_out,
  output logic [2:0]               o_ch_id_out
);

  function automatic win_cfg_t default_cfg(input int k);
    win_cfg_t c;
    c.en = 1'b1;
    c.x0 = 10'(k * (IMG_WIDTH << SCALE_SHIFT));
    c.y0 = 10'(V_ACTIVE - (IMG_HEIGHT << SCALE_SHIFT));
    return c;
  endfunction

  win_cfg_t          r_pend [NUM_CH];
  win_cfg_t          r_act  [NUM_CH];
  logic              r_vs_prev;
  logic              w_commit, w_diff;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] r_hit_d  [RD_LATENCY];
  side_t             r_side_d [RD_LATENCY+1];
  side_t             w_side_in, w_side;
  logic [NUM_CH-1:0] w_ch_hit;
  rgb444_t           w_rgb;
  logic [2:0]        w_id;

  assign w_commit = i_v_sync && !r_vs_prev;

  always_comb begin
    w_diff = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (r_pend[k] != r_act[k]) w_diff = 1'b1;
  end

  // Active is copied before this cycle's write lands, so a write on the commit cycle waits a frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_pend[k] <= default_cfg(k);
        r_act[k]  <= default_cfg(k);
      end
      r_vs_prev     <= 1'b0;
      o_cfg_applied <= 1'b0;
    end else begin
      r_vs_prev     <= i_v_sync;
      o_cfg_applied <= w_commit && w_diff;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_commit) r_act[k] <= r_pend[k];
        if (i_cfg_valid && (i_cfg_ch == 2'(k)))
          r_pend[k] <= '{en: i_cfg_en, x0: i_cfg_x0, y0: i_cfg_y0};
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cam_window_addr_gen #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .SCALE_SHIFT(SCALE_SHIFT),
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .ADDR_W     (ADDR_W)
    ) u_addr_gen (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_en   (r_act[k].en),
      .i_x    (i_x_pixel),
      .i_y    (i_y_pixel),
      .i_x0   (r_act[k].x0),
      .i_y0   (r_act[k].y0),
      .o_hit  (w_hit[k]),
      .o_addr (o_rd_addr[k*ADDR_W +: ADDR_W])
    );
  end

  assign w_side_in = '{de: i_de, h_sync: i_h_sync, v_sync: i_v_sync,
                       ui_en: i_ui_en, ui_rgb: i_ui_rgb};

  // Hits are already one stage in, so they need RD_LATENCY more; sideband needs one extra.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LATENCY; i++) r_hit_d[i] <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) r_side_d[i] <= '0;
    end else begin
      r_hit_d[0]  <= w_hit;
      r_side_d[0] <= w_side_in;
      for (int i = 1; i < RD_LATENCY; i++) r_hit_d[i] <= r_hit_d[i-1];
      for (int i = 1; i <= RD_LATENCY; i++) r_side_d[i] <= r_side_d[i-1];
    end
  end

  assign w_ch_hit = r_hit_d[RD_LATENCY-1];
  assign w_side   = r_side_d[RD_LATENCY];

  // Descending scan so the lowest hitting channel is the last assignment and wins.
  always_comb begin
    w_rgb = BG_RGB;
    w_id  = CH_BG;
    if (!w_side.de) begin
      w_rgb = '0;
    end else if (w_side.ui_en) begin
      w_rgb = w_side.ui_rgb;
      w_id  = CH_UI;
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (w_ch_hit[k]) begin
          w_rgb = rgb565_to_444(i_rd_data[k*16 +: 16]);
          w_id  = 3'(k);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rgb_out    <= '0;
      o_de_out     <= 1'b0;
      o_h_sync_out <= 1'b0;
      o_v_sync_out <= 1'b0;
      o_ch_id_out  <= CH_BG;
    end else begin
      o_rgb_out    <= w_rgb;
      o_de_out     <= w_side.de;
      o_h_sync_out <= w_side.h_sync;
      o_v_sync_out <= w_side.v_sync;
      o_ch_id_out  <= w_id;
    end
  end

endmodule

// File: tb/tb_multi_cam_compositor.sv
// Scoreboard bench for multi_cam_compositor: a window/priority reference model queues
// expected addresses and pixels per cycle; an independent monitor pops and compares.
module tb_multi_cam_compositor;

  localparam int NCH    = 2;
  localparam int AW     = 15;
  localparam int WIN_W  = 320;
  localparam int WIN_H  = 240;

  logic             clk = 1'b0;
  logic             reset, de, hSync, vSync, uiEn, cfgValid, cfgEn;
  logic [9:0]       xPixel, yPixel, cfgX0, cfgY0;
  logic [1:0]       cfgCh;
  logic [11:0]      uiRgb;
  logic [NCH*AW-1:0] rdAddr;
  logic [NCH*16-1:0] rdData = '0;
  logic             cfgApplied, deOut, hsOut, vsOut;
  logic [11:0]      rgbOut;
  logic [2:0]       chIdOut;

  multi_cam_compositor #(
    .NUM_CH(NCH), .IMG_WIDTH(160), .IMG_HEIGHT(120), .SCALE_SHIFT(1),
    .H_ACTIVE(640), .V_ACTIVE(480), .RD_LATENCY(1), .BG_RGB(12'h000)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_de(de), .i_h_sync(hSync), .i_v_sync(vSync),
    .i_x_pixel(xPixel), .i_y_pixel(yPixel), .o_rd_addr(rdAddr), .i_rd_data(rdData),
    .i_ui_en(uiEn), .i_ui_rgb(uiRgb), .i_cfg_valid(cfgValid), .i_cfg_ch(cfgCh),
    .i_cfg_en(cfgEn), .i_cfg_x0(cfgX0), .i_cfg_y0(cfgY0), .o_cfg_applied(cfgApplied),
    .o_rgb_out(rgbOut), .o_de_out(deOut), .o_h_sync_out(hsOut), .o_v_sync_out(vsOut),
    .o_ch_id_out(chIdOut)
  );

  always #5 clk = ~clk;

  int posCount = 0;
  always @(posedge clk) posCount <= posCount + 1;

  // Frame-buffer stand-in: one cycle read latency, content is a fixed function of (channel, address).
  function automatic logic [15:0] fbWord(input int k, input int a);
    return 16'((a * 37 + k * 9001 + 23130) % 65536);
  endfunction

  always @(posedge clk)
    for (int k = 0; k < NCH; k++)
      rdData[k*16 +: 16] <= fbWord(k, int'(rdAddr[k*AW +: AW]));

  typedef struct { int cyc; logic [NCH*AW-1:0] addr; logic applied; } addrExpT;
  typedef struct { int cyc; logic [11:0] rgb; logic [2:0] id; logic de, hs, vs; } pixExpT;
  addrExpT addrQ[$];
  pixExpT  pixQ[$];

  int checks = 0;
  int errors = 0;

  int aEn[NCH], aX0[NCH], aY0[NCH];
  int pEn[NCH], pX0[NCH], pY0[NCH];
  logic vsPrev = 1'b0;

  function automatic logic [11:0] to444(input logic [15:0] d);
    int r, g, b;
    r = int'(d) / 4096;
    g = (int'(d) / 128) % 16;
    b = (int'(d) / 2) % 16;
    return 12'(r * 256 + g * 16 + b);
  endfunction

  task automatic loadDefaults();
    for (int k = 0; k < NCH; k++) begin
      aEn[k] = 1; aX0[k] = k * WIN_W; aY0[k] = 480 - WIN_H;
      pEn[k] = 1; pX0[k] = k * WIN_W; pY0[k] = 480 - WIN_H;
    end
    vsPrev = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, posCount, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic d, input logic hs, input logic vs,
                               input int x, input int y, input logic ue, input logic [11:0] uc,
                               input logic cv, input logic [1:0] cch, input logic ce,
                               input logic [9:0] cx, input logic [9:0] cy);
    int e, win;
    bit commit, diff;
    addrExpT a;
    pixExpT p;
    @(negedge clk);
    reset = rst; de = d; hSync = hs; vSync = vs; xPixel = 10'(x); yPixel = 10'(y);
    uiEn = ue; uiRgb = uc; cfgValid = cv; cfgCh = cch; cfgEn = ce; cfgX0 = cx; cfgY0 = cy;
    e = posCount + 1;
    if (rst) begin
      while (addrQ.size() > 0 && addrQ[$].cyc >= e) void'(addrQ.pop_back());
      while (pixQ.size() > 0 && pixQ[$].cyc >= e) void'(pixQ.pop_back());
      a.cyc = e; a.addr = '0; a.applied = 1'b0;
      addrQ.push_back(a);
      for (int i = 0; i < 3; i++) begin
        p.cyc = e + i; p.rgb = 12'h000; p.id = 3'd7; p.de = 0; p.hs = 0; p.vs = 0;
        pixQ.push_back(p);
      end
      loadDefaults();
      return;
    end
    a.cyc = e; a.addr = '0;
    win = -1;
    for (int k = 0; k < NCH; k++) begin
      if (aEn[k] != 0 && x >= aX0[k] && x < aX0[k] + WIN_W && x < 640 &&
          y >= aY0[k] && y < aY0[k] + WIN_H && y < 480) begin
        a.addr[k*AW +: AW] = AW'(((y - aY0[k]) / 2) * 160 + (x - aX0[k]) / 2);
        if (win < 0) win = k;
      end
    end
    p.cyc = e + 2; p.de = d; p.hs = hs; p.vs = vs;
    if (!d) begin
      p.rgb = 12'h000; p.id = 3'd7;
    end else if (ue) begin
      p.rgb = uc; p.id = 3'd6;
    end else if (win >= 0) begin
      p.rgb = to444(fbWord(win, int'(a.addr[win*AW +: AW]))); p.id = 3'(win);
    end else begin
      p.rgb = 12'h000; p.id = 3'd7;
    end
    commit = vs && !vsPrev;
    diff = 0;
    for (int k = 0; k < NCH; k++)
      if (aEn[k] != pEn[k] || aX0[k] != pX0[k] || aY0[k] != pY0[k]) diff = 1;
    a.applied = commit && diff;
    addrQ.push_back(a);
    pixQ.push_back(p);
    if (commit)
      for (int k = 0; k < NCH; k++) begin aEn[k] = pEn[k]; aX0[k] = pX0[k]; aY0[k] = pY0[k]; end
    if (cv && int'(cch) < NCH) begin
      pEn[cch] = int'(ce); pX0[cch] = int'(cx); pY0[cch] = int'(cy);
    end
    vsPrev = vs;
  endtask

  always @(negedge clk) begin
    addrExpT a;
    pixExpT p;
    if (addrQ.size() > 0 && addrQ[0].cyc == posCount) begin
      a = addrQ.pop_front();
      for (int k = 0; k < NCH; k++)
        checkOutput($sformatf("rdAddr%0d", k), 32'(rdAddr[k*AW +: AW]), 32'(a.addr[k*AW +: AW]));
      checkOutput("cfgApplied", 32'(cfgApplied), 32'(a.applied));
    end
    if (pixQ.size() > 0 && pixQ[0].cyc == posCount) begin
      p = pixQ.pop_front();
      checkOutput("rgbOut", 32'(rgbOut), 32'(p.rgb));
      checkOutput("chIdOut", 32'(chIdOut), 32'(p.id));
      checkOutput("deOut", 32'(deOut), 32'(p.de));
      checkOutput("hSyncOut", 32'(hsOut), 32'(p.hs));
      checkOutput("vSyncOut", 32'(vsOut), 32'(p.vs));
    end
  end

  task automatic pix(input int x, input int y, input logic d = 1'b1, input logic ue = 1'b0);
    applyStimulus(0, d, 0, 0, x, y, ue, 12'h5A3, 0, 2'd0, 0, 10'd0, 10'd0);
  endtask

  task automatic cfgW(input logic [1:0] ch, input logic en, input int x0, input int y0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h000, 1, ch, en, 10'(x0), 10'(y0));
  endtask

  task automatic commitFrame();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 2'd0, 0, 10'd0, 10'd0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h000, 0, 2'd0, 0, 10'd0, 10'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 2'd0, 0, 10'd0, 10'd0);
  endtask

  initial begin
    reset = 1; de = 0; hSync = 0; vSync = 0; xPixel = '0; yPixel = '0; uiEn = 0; uiRgb = '0;
    cfgValid = 0; cfgCh = '0; cfgEn = 0; cfgX0 = '0; cfgY0 = '0;
    loadDefaults();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 12'h000, 0, 2'd0, 0, 10'd0, 10'd0);

    pix(330, 250); pix(5, 245); pix(319, 479); pix(320, 239); pix(100, 100);

    cfgW(2'd1, 1, 0, 240);
    pix(10, 260); pix(400, 300);
    commitFrame();
    pix(10, 260); pix(400, 300);
    cfgW(2'd0, 0, 0, 240);
    commitFrame();
    pix(10, 260); pix(10, 260, 1'b1, 1'b1);

    cfgW(2'd0, 1, 600, 0);
    cfgW(2'd3, 0, 5, 5);
    commitFrame();
    for (int x = 596; x < 648; x += 3) pix(x, 10);
    pix(1023, 10); pix(639, 239); pix(639, 240);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 2'd0, 0, 10'd0, 10'd0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h000, 1, 2'd1, 0, 10'd0, 10'd0);
    pix(10, 260); pix(620, 20);
    commitFrame();
    pix(10, 260);

    cfgW(2'd0, 0, 0, 0); cfgW(2'd1, 0, 0, 0);
    commitFrame();
    pix(330, 250); pix(10, 300, 1'b0); pix(5, 5);
    commitFrame();

    pix(620, 300); pix(621, 301);
    applyStimulus(1, 1, 1, 1, 330, 250, 0, 12'h000, 0, 2'd0, 0, 10'd0, 10'd0);
    pix(330, 250); pix(10, 260); pix(620, 20); pix(100, 479);

    for (int i = 0; i < 3000; i++) begin
      int x, y;
      x = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 700));
      y = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 520));
      applyStimulus($urandom_range(0, 599) == 0, $urandom_range(0, 5) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, x, y,
                    $urandom_range(0, 7) == 0, 12'($urandom()), $urandom_range(0, 14) == 0,
                    2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 400)),
                    ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 300)));
    end

    repeat (5) @(negedge clk);
    checkOutput("addrQueueDrained", 32'(addrQ.size()), 32'd0);
    checkOutput("pixQueueDrained", 32'(pixQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
